mouse_accum: RTL

MOUSE_ACCUM -- requirements
Module: mouse_accum

---
 rtl/mouse_accum.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mouse_accum.sv
`default_nettype none
//============================================================================
// Module      : mouse_accum
// Description : Accumulates PS/2 mouse motion packets into saturating 9-bit
//               signed X/Y counters and tracks button state. A new packet is
//               flagged by a toggle on ps2_mouse[24]. The packet is captured
//               one cycle after the toggle is seen and applied one cycle
//               later, so the outputs move two clk_sys edges after the toggle.
//               Per-axis consume strobes zero the counters. When a strobe
//               lands in the same cycle as a packet, that axis restarts from
//               the packet's delta.
// Ports       : clk_sys      - system clock, rising edge
//               reset        - asynchronous active-high reset
//               ps2_mouse    - [24] toggle, [23:16] Y, [15:8] X, [7:0] status
//               clr_x/clr_y  - one-cycle consume strobes per axis
//               mouse_x/y    - signed accumulated motion, [-256, +255]
//               mouse_left/middle/right - button state, active-high
//               moved        - registered (mouse_x != 0) | (mouse_y != 0)
// Revision    : 1.0 - initial release
//============================================================================
module mouse_accum #(
    parameter int INVERT_Y = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic        clr_x,
    input  logic        clr_y,
    output logic [8:0]  mouse_x,
    output logic [8:0]  mouse_y,
    output logic        mouse_left,
    output logic        mouse_middle,
    output logic        mouse_right,
    output logic        moved
);

    localparam logic signed [10:0] c_MAX = 11'sd255;
    localparam logic signed [10:0] c_MIN = -11'sd256;

    // Toggle history: no reset, so it keeps following the host toggle while
    // reset is held and the level present at release is never seen as a packet.
    logic        r_tog;
    logic        w_new;

    // Capture stage
    logic [23:0] r_cap;
    logic        r_pend;

    // Delta and next-state computation
    logic [7:0]         w_status;
    logic [8:0]         w_dx9;
    logic [8:0]         w_dy9;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy_raw;
    logic signed [10:0] w_dy;
    logic signed [10:0] w_base_x;
    logic signed [10:0] w_base_y;
    logic [8:0]         w_next_x;
    logic [8:0]         w_next_y;
    logic               w_next_moved;
    logic               w_unused_status3;

    function automatic logic [8:0] f_clamp(input logic signed [10:0] v);
        if (v > c_MAX) begin
            return 9'h0FF;
        end else if (v < c_MIN) begin
            return 9'h100;
        end else begin
            return v[8:0];
        end
    endfunction

    always_ff @(posedge clk_sys) begin
        r_tog <= ps2_mouse[24];
    end

    assign w_new = ps2_mouse[24] ^ r_tog;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cap  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_new;
            if (w_new) begin
                r_cap <= ps2_mouse[23:0];
            end
        end
    end

    assign w_status         = r_cap[7:0];
    // The "always 1" status bit carries no information and is not checked.
    assign w_unused_status3 = w_status[3];

    always_comb begin
        w_dx9 = {w_status[4], r_cap[15:8]};
        if (w_status[6]) begin
            w_dx9 = w_status[4] ? 9'h100 : 9'h0FF;
        end
        w_dy9 = {w_status[5], r_cap[23:16]};
        if (w_status[7]) begin
            w_dy9 = w_status[5] ? 9'h100 : 9'h0FF;
        end

        w_dx     = {{2{w_dx9[8]}}, w_dx9};
        w_dy_raw = {{2{w_dy9[8]}}, w_dy9};
        // Negating in the wider type lets -256 become +256 before clamping.
        w_dy     = (INVERT_Y != 0) ? -w_dy_raw : w_dy_raw;

        // A clear in the same cycle as a packet discards the old value but
        // still applies the packet.
        w_base_x = clr_x ? 11'sd0 : {{2{mouse_x[8]}}, mouse_x};
        w_base_y = clr_y ? 11'sd0 : {{2{mouse_y[8]}}, mouse_y};

        if (r_pend) begin
            w_next_x = f_clamp(w_base_x + w_dx);
            w_next_y = f_clamp(w_base_y + w_dy);
        end else begin
            w_next_x = w_base_x[8:0];
            w_next_y = w_base_y[8:0];
        end

        w_next_moved = (|w_next_x) | (|w_next_y);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mouse_x      <= '0;
            mouse_y      <= '0;
            mouse_left   <= 1'b0;
            mouse_middle <= 1'b0;
            mouse_right  <= 1'b0;
            moved        <= 1'b0;
        end else begin
            mouse_x <= w_next_x;
            mouse_y <= w_next_y;
            moved   <= w_next_moved;
            if (r_pend) begin
                mouse_left   <= w_status[0];
                mouse_right  <= w_status[1];
                mouse_middle <= w_status[2];
            end
        end
    end

endmodule
`default_nettype wire
